ysyx_22040931_ifu: RTL and testbench
====================================

// Module: ysyx_22040931_ifu
// PURPOSE
//   Instruction fetch unit: producer side of the decode interface. Holds the PC, issues
//   word fetches on a valid/ready instruction-memory port, and presents {pc, inst, opcode}
//   to the decode stage (U-type/I-type/... opcode decoders) over a valid/ready handshake.
//   Accepts PC redirects from execute; squashes any wrong-path fetch in flight.
// PARAMETERS
//   XLEN      32            data/address width
//   RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//   clk             in   1     clock, all state on rising edge
//   rst             in   1     asynchronous, active-high reset
//   redirect_valid  in   1     execute requests PC change (branch/jump/trap)
//   redirect_pc     in   XLEN  redirect target; bits [1:0] ignored
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  fetch address, [1:0]=2'b00
//   imem_rsp_valid  in   1     response valid (one per accepted request, in order)
//   imem_rsp_data   in   32    fetched instruction word
//   imem_rsp_err    in   1     access fault for this response
//   id_valid        out  1     instruction valid to decode
//   id_ready        in   1     decode accepts instruction
//   id_pc           out  XLEN  PC of presented instruction
//   id_inst         out  32    presented instruction
//   id_opcode       out  7     id_inst[6:0], feeds opcode decoders
//   id_fault        out  1     presented instruction had imem_rsp_err
//   perf_inst_cnt   out  32    instructions handed to decode (see CONFIGURATION)
//   perf_wait_cnt   out  32    cycles spent in WAIT (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, state=REQ, kill=0, hold buffer cleared; imem_req_valid=0,
//     id_valid=0, id_pc/id_inst=0, id_fault=0, perf counters=0 while rst high.
//   FSM states REQ / WAIT / HOLD:
//   - REQ: imem_req_valid=1, addr=pc. req_ready -> WAIT. Without ready, addr held unless redirect.
//   - WAIT: await imem_rsp_valid. rsp & !kill & !redirect -> latch data/err/pc into hold
//     buffer -> HOLD. rsp & kill -> drop, kill<=0 -> REQ. Responses outside WAIT ignored.
//   - HOLD: id_valid=1, id_pc/id_inst/id_fault stable. id_ready -> pc<=pc+4 -> REQ.
//   Latency: fetch handed to decode >= 2 cycles after request accept (REQ->WAIT->HOLD);
//     min 3 cycles per instruction with zero-wait memory; no overlap of fetches.
//   Redirect (highest priority, any state): pc<={redirect_pc[XLEN-1:2],2'b00} next edge.
//   - REQ without ready: stay REQ, new addr next cycle (request address may change
//     before acceptance; memory must tolerate this).
//   - REQ with ready same cycle: request counted as issued -> WAIT with kill=1.
//   - WAIT: kill<=1 (rsp same cycle as redirect: dropped, -> REQ directly).
//   - HOLD: id_valid gated combinationally: id_valid = hold & ~redirect_valid; id_ready
//     that cycle is not a handshake; -> REQ with redirect pc.
//   pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). Only one request outstanding ever.
//   Reset mid-operation discards all state; memory must share rst so no stale rsp arrives.
//   id_fault instructions are presented unchanged; decode/exec raises the trap.
// CONFIGURATION
//   YSYX_22040931_IFU_PERF_EN defined: perf_inst_cnt +1 per id_valid&id_ready;
//     perf_wait_cnt +1 per cycle in WAIT; both wrap at 2^32, reset to 0.
//   Undefined: counters not built, perf_inst_cnt/perf_wait_cnt tied to 0.
// TESTING
//   1. Release rst, req_ready=1, rsp 1 cycle later data=32'h0000_0537 -> req addr
//      8000_0000; id_valid with id_pc=8000_0000, id_opcode=7'b0110111; next req 8000_0004.
//   2. HOLD with id_ready=0 for 5 cycles -> id_valid/id_inst/id_pc stable, req_valid=0.
//   3. Redirect to 32'h8000_0102 in WAIT, rsp next cycle -> rsp dropped, id_valid never
//      asserted for it, next req addr 8000_0100.
//   4. HOLD, id_ready=1 and redirect_valid=1 to 8000_0200 same cycle -> id_valid=0 that
//      cycle, no perf increment, next req addr 8000_0200.
//   5. Assert rst mid-WAIT -> req_valid/id_valid drop immediately; after release first
//      req addr 8000_0000.
//   6. 10 back-to-back instructions: with YSYX_22040931_IFU_PERF_EN perf_inst_cnt=10,
//      perf_wait_cnt=10 (1-cycle rsp); without macro both read 0.

Source files
------------

// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time on the
// imem valid/ready port, and presents {pc, inst, opcode, fault} to decode.
// Redirects from execute take effect on the next edge; a fetch already
// accepted by memory is marked killed and its response is dropped.
// Optional feature macro: YSYX_22040931_IFU_PERF_EN builds the perf counters;
// without it perf_inst_cnt/perf_wait_cnt are tied to zero.
//
// state  | meaning
// S_REQ  | fetch request presented at pc, waiting for imem_req_ready
// S_WAIT | request accepted, waiting for its response (kill = wrong path)
// S_HOLD | instruction held in buffer and offered to decode
module ysyx_22040931_ifu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic [6:0]      id_opcode,
  output logic            id_fault,
  output logic [31:0]     perf_inst_cnt,
  output logic [31:0]     perf_wait_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic            kill, kill_n;
  logic            hold_ld;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_inst;
  logic            hold_fault;
  logic [XLEN-1:0] redirect_aligned;

  // Low two bits of the redirect target are dropped by masking so the whole
  // input bus is consumed.
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // State, PC and kill flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
    end
  end

  // Next-state logic; a redirect overrides the PC from any state.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    hold_ld = 1'b0;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          state_n = S_WAIT;
          kill_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_n = 1'b0;
          if (!kill && !redirect_valid) begin
            state_n = S_HOLD;
            hold_ld = 1'b1;
          end else begin
            state_n = S_REQ;
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_n = S_REQ;
        end else if (id_ready) begin
          state_n = S_REQ;
          pc_n    = pc + XLEN'(4);
        end
      end
      default: state_n = S_REQ;
    endcase
    if (redirect_valid) pc_n = redirect_aligned;
  end

  // Hold buffer captures the accepted response and its fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_pc    <= '0;
      hold_inst  <= '0;
      hold_fault <= 1'b0;
    end else if (hold_ld) begin
      hold_pc    <= pc;
      hold_inst  <= imem_rsp_data;
      hold_fault <= imem_rsp_err;
    end
  end

  // The state register resets to S_REQ, so the request is masked while rst is high.
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign id_valid       = (state == S_HOLD) && !redirect_valid;
  assign id_pc          = hold_pc;
  assign id_inst        = hold_inst;
  assign id_opcode      = hold_inst[6:0];
  assign id_fault       = hold_fault;

`ifdef YSYX_22040931_IFU_PERF_EN
  // Retired-to-decode and memory-wait counters, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_cnt <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (id_valid && id_ready) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (state == S_WAIT)      perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`else
  assign perf_inst_cnt = '0;
  assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized run with a
// memory model. The reference is the architectural instruction stream: decode
// must see mem[pc], pc advancing by 4 per handoff and jumping on redirect.
module tb_ysyx_22040931_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef YSYX_22040931_IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_inst;
  logic [6:0]  id_opcode;
  logic        id_fault;
  logic [31:0] perf_inst_cnt, perf_wait_cnt;

  ysyx_22040931_ifu dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_opcode(id_opcode), .id_fault(id_fault),
    .perf_inst_cnt(perf_inst_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  bit   mon_en = 1'b0;

  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h8000_0537;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'hB;
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.inst  = mem_data(pc);
    e.fault = mem_err(pc);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against the head
  // of the expected stream and advances the stream on each handshake.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (q.size() == 0) begin
        check("sb_nonempty", 32'(q.size()), 32'd1);
      end else begin
        if (imem_req_valid && !redirect_valid)
          check("req_addr", imem_req_addr, q[0].pc);
        if (redirect_valid)
          check("id_valid_gated", 32'(id_valid), 32'd0);
        if (id_valid) begin
          check("id_pc", id_pc, q[0].pc);
          check("id_inst", id_inst, q[0].inst);
          check("id_fault", 32'(id_fault), 32'(q[0].fault));
          check("id_opcode", 32'(id_opcode), 32'(q[0].inst[6:0]));
          if (id_ready) begin
            mon_e = q.pop_front();
            q.push_back(mk(mon_e.pc + 32'd4));
            hs_cnt++;
          end
        end
      end
    end
  end

  // One clock of stimulus; also runs the single-outstanding memory model.
  task automatic step(input int lat_lo, input int lat_hi, output bit acc, output bit hs);
    logic [31:0] a;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    hs  = id_valid && id_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_cnt  = int'($urandom_range(lat_hi, lat_lo));
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(pend_addr);
        imem_rsp_err   = mem_err(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    q.delete();
    q.push_back(mk({target[31:2], 2'b00}));
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    mon_en         = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    pend           = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);
    check("rst_id_fault", 32'(id_fault), 32'd0);
    check("rst_perf_inst", perf_inst_cnt, 32'd0);
    check("rst_perf_wait", perf_wait_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    q.push_back(mk(RESET_PC));
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc, hs;
    int n, hs6, last_hs;
    logic [31:0] tgt;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    id_ready       = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // first fetch and its latency
    imem_req_ready = 1'b1;
    for (n = 0; n < 20 && !id_valid; n++) step(0, 0, acc, hs);
    check("t1_latency", 32'(n), 32'd2);
    check("t1_id_pc", id_pc, 32'h8000_0000);
    check("t1_id_inst", id_inst, 32'h0000_0537);
    check("t1_opcode", 32'(id_opcode), 32'h37);

    // decode stalls: instruction held, no new request
    repeat (5) begin
      step(0, 0, acc, hs);
      check("t2_hold_valid", 32'(id_valid), 32'd1);
      check("t2_req_idle", 32'(imem_req_valid), 32'd0);
      check("t2_hold_pc", id_pc, 32'h8000_0000);
    end
    id_ready = 1'b1;
    step(0, 0, acc, hs);
    id_ready = 1'b0;
    check("t1_next_valid", 32'(imem_req_valid), 32'd1);
    check("t1_next_addr", imem_req_addr, 32'h8000_0004);

    // redirect while waiting, response one cycle later is dropped
    acc = 1'b0;
    for (n = 0; n < 20 && !acc; n++) step(1, 1, acc, hs);
    check("t3_accepted", 32'(acc), 32'd1);
    do_redirect(32'h8000_0102);
    for (n = 0; n < 10 && !(imem_req_valid && !redirect_valid); n++) begin
      step(1, 1, acc, hs);
      check("t3_no_id", 32'(id_valid), 32'd0);
    end
    check("t3_req_valid", 32'(imem_req_valid), 32'd1);
    check("t3_req_addr", imem_req_addr, 32'h8000_0100);

    // handshake attempt coinciding with redirect
    for (n = 0; n < 20 && !id_valid; n++) step(0, 0, acc, hs);
    check("t4_in_hold", 32'(id_valid), 32'd1);
    id_ready = 1'b1;
    do_redirect(32'h8000_0200);
    #1;
    check("t4_id_gated", 32'(id_valid), 32'd0);
    step(0, 0, acc, hs);
    id_ready = 1'b0;
    check("t4_no_perf", perf_inst_cnt, PERF ? 32'd1 : 32'd0);
    check("t4_req_addr", imem_req_addr, 32'h8000_0200);

    // reset in the middle of a wait
    acc = 1'b0;
    for (n = 0; n < 20 && !acc; n++) step(3, 3, acc, hs);
    check("t5_accepted", 32'(acc), 32'd1);
    do_reset();
    #1;
    check("t5_req_valid", 32'(imem_req_valid), 32'd1);
    check("t5_req_addr", imem_req_addr, RESET_PC);

    // ten back-to-back instructions with zero-wait memory
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    hs6     = 0;
    last_hs = -1;
    for (n = 0; n < 100 && hs6 < 10; n++) begin
      step(0, 0, acc, hs);
      if (hs) begin
        if (last_hs >= 0) check("t6_gap", 32'(n - last_hs), 32'd3);
        last_hs = n;
        hs6++;
      end
    end
    imem_req_ready = 1'b0;
    id_ready       = 1'b0;
    check("t6_count", 32'(hs6), 32'd10);
    #1;
    check("t6_perf_inst", perf_inst_cnt, PERF ? 32'd10 : 32'd0);
    check("t6_perf_wait", perf_wait_cnt, PERF ? 32'd10 : 32'd0);

    // randomized traffic with redirects, stalls and variable memory latency
    n = hs_cnt;
    for (int i = 0; i < 1500; i++) begin
      step(0, 3, acc, hs);
      imem_req_ready = ($urandom % 4) != 0;
      id_ready       = ($urandom % 2) != 0;
      if (($urandom % 12) == 0) begin
        if (($urandom % 4) == 0) tgt = 32'hFFFF_FFF0 | ($urandom % 16);
        else                     tgt = 32'h8000_0000 + $urandom_range(1023, 0);
        do_redirect(tgt);
      end
    end
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (10) step(0, 0, acc, hs);
    check("rand_progress", 32'(hs_cnt - n >= 30), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
